// File: rtl/ddr3_bridge_pkg.sv
// rtl/ddr3_bridge_pkg.sv - shared command codes, burst geometry and FSM states for the DDR3 app bridge
package ddr3_bridge_pkg;

  localparam logic [2:0] DRAM_WRITE = 3'b000;
  localparam logic [2:0] DRAM_READ  = 3'b001;

  localparam int BURST_ADDR_STEP = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } bridge_state_e;

endpackage

// File: rtl/bridge_sync_fifo.sv
// rtl/bridge_sync_fifo.sv - first-word-fall-through synchronous FIFO, DEPTH a power of 2
module bridge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             dram_clk,
  input  logic             reset_dram,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop frees the slot the same cycle, so a push into a full FIFO is fine alongside it.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge dram_clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge dram_clk or posedge reset_dram) begin
    if (reset_dram) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ddr3_app_bridge.sv
// rtl/ddr3_app_bridge.sv - request front-end for the DDR3 controller user port
// Optional statistics counters enabled by defining DDR3_BRIDGE_STATS_EN.
module ddr3_app_bridge
  import ddr3_bridge_pkg::*;
#(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 256,
  parameter int MASK_W  = 32,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic              dram_clk,
  input  logic              reset_dram,
  input  logic              init_calib_complete,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              err_unexpected,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_stall
);

  localparam int CRED_W = $clog2(MAX_OUT) + 1;
  localparam int RSP_W  = TAG_W + DATA_W;
  localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(BURST_ADDR_STEP - 1);

  bridge_state_e     state;
  logic              cmd_acked;
  logic              wd_acked;
  logic [TAG_W-1:0]  tag_r;
  logic [CRED_W-1:0] credits;

  logic              cmd_fire;
  logic              wd_fire;
  logic              is_write;
  logic              req_fire;
  logic              rd_accept;
  logic              issue_done;
  logic              tag_push;
  logic              rsp_pop;
  logic              rd_match;

  logic [TAG_W-1:0]  tag_head;
  logic              tag_empty;
  logic              tag_full_unused;
  logic [RSP_W-1:0]  rsp_head;
  logic              rsp_empty;
  logic              rsp_full_unused;

  assign cmd_fire  = app_en && app_rdy;
  assign wd_fire   = app_wdf_wren && app_wdf_rdy;
  assign is_write  = (app_cmd == DRAM_WRITE);
  assign req_ready = !reset_dram && (state == ST_IDLE) && init_calib_complete &&
                     (req_write || (credits != '0));
  assign req_fire  = req_valid && req_ready;
  assign rd_accept = req_fire && !req_write;

  // Either channel may already have been acknowledged in an earlier cycle.
  assign issue_done = (state == ST_ISSUE) &&
                      (is_write ? ((cmd_acked || cmd_fire) && (wd_acked || wd_fire)) : cmd_fire);
  assign tag_push   = (state == ST_ISSUE) && !is_write && cmd_fire;
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign rd_match   = app_rd_data_valid && !tag_empty;

  always_ff @(posedge dram_clk or posedge reset_dram) begin
    if (reset_dram) begin
      state        <= ST_IDLE;
      app_cmd      <= DRAM_READ;
      app_en       <= 1'b0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      cmd_acked    <= 1'b0;
      wd_acked     <= 1'b0;
      tag_r        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            app_addr <= req_addr & ADDR_ALIGN;
            app_cmd  <= req_write ? DRAM_WRITE : DRAM_READ;
            app_en   <= 1'b1;
            tag_r    <= req_tag;
            if (req_write) begin
              app_wdf_data <= req_wdata;
              app_wdf_mask <= req_wmask;
              app_wdf_wren <= 1'b1;
              app_wdf_end  <= 1'b1;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_fire) begin
            app_en    <= 1'b0;
            cmd_acked <= 1'b1;
          end
          if (wd_fire) begin
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            wd_acked     <= 1'b1;
          end
          if (issue_done) begin
            cmd_acked <= 1'b0;
            wd_acked  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Credits cover every read from accept until its response leaves the rsp port.
  always_ff @(posedge dram_clk or posedge reset_dram) begin
    if (reset_dram) begin
      credits <= CRED_W'(MAX_OUT);
    end else begin
      case ({rd_accept, rsp_pop})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge dram_clk or posedge reset_dram) begin
    if (reset_dram) begin
      err_unexpected <= 1'b0;
    end else if (app_rd_data_valid && tag_empty) begin
      err_unexpected <= 1'b1;
    end
  end

  bridge_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUT)) u_tag_fifo (
    .dram_clk   (dram_clk),
    .reset_dram (reset_dram),
    .push       (tag_push),
    .push_data  (tag_r),
    .pop        (rd_match),
    .pop_data   (tag_head),
    .full       (tag_full_unused),
    .empty      (tag_empty)
  );

  bridge_sync_fifo #(.WIDTH(RSP_W), .DEPTH(MAX_OUT)) u_rsp_fifo (
    .dram_clk   (dram_clk),
    .reset_dram (reset_dram),
    .push       (rd_match),
    .push_data  ({tag_head, app_rd_data}),
    .pop        (rsp_pop),
    .pop_data   (rsp_head),
    .full       (rsp_full_unused),
    .empty      (rsp_empty)
  );

  assign rsp_valid = !rsp_empty;
  assign rsp_tag   = rsp_valid ? rsp_head[RSP_W-1 -: TAG_W] : '0;
  assign rsp_data  = rsp_valid ? rsp_head[DATA_W-1:0] : '0;

`ifdef DDR3_BRIDGE_STATS_EN
  always_ff @(posedge dram_clk or posedge reset_dram) begin
    if (reset_dram) begin
      stat_wr    <= '0;
      stat_rd    <= '0;
      stat_stall <= '0;
    end else begin
      if (issue_done && is_write) stat_wr <= stat_wr + 32'd1;
      if (tag_push)               stat_rd <= stat_rd + 32'd1;
      if ((state == ST_ISSUE) &&
          ((app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy))) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`else
  assign stat_wr    = '0;
  assign stat_rd    = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_ddr3_app_bridge.sv
// tb/tb_ddr3_app_bridge.sv - self-checking bench for ddr3_app_bridge with a response scoreboard
module tb_ddr3_app_bridge;

  logic         dram_clk = 1'b0;
  logic         reset_dram;
  logic         init_calib_complete;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [27:0]  req_addr;
  logic [255:0] req_wdata;
  logic [31:0]  req_wmask;
  logic [3:0]   req_tag;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_data;
  logic [3:0]   rsp_tag;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [27:0]  app_addr;
  logic         app_rdy;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         err_unexpected;
  logic [31:0]  stat_wr;
  logic [31:0]  stat_rd;
  logic [31:0]  stat_stall;

  int checks = 0;
  int errors = 0;

  logic [3:0]   pend_q[$];
  logic [259:0] exp_q[$];

  always #5 dram_clk = ~dram_clk;

  ddr3_app_bridge dut (
    .dram_clk            (dram_clk),
    .reset_dram          (reset_dram),
    .init_calib_complete (init_calib_complete),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_wmask           (req_wmask),
    .req_tag             (req_tag),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_tag             (rsp_tag),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .err_unexpected      (err_unexpected),
    .stat_wr             (stat_wr),
    .stat_rd             (stat_rd),
    .stat_stall          (stat_stall)
  );

  task automatic check(input string name, input logic [259:0] got, input logic [259:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] rd_pattern(input logic [3:0] t);
    logic [31:0] w;
    w = {24'hD0D0D0, 4'h0, t};
    return {8{w}};
  endfunction

  task automatic send_req(input logic wr, input logic [27:0] addr, input logic [255:0] d,
                          input logic [31:0] m, input logic [3:0] t);
    bit ok;
    ok = 0;
    @(posedge dram_clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = d; req_wmask = m; req_tag = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge dram_clk);
      if (req_ready) begin ok = 1; break; end
    end
    check("req_accept", {259'b0, ok}, 260'd1);
    @(posedge dram_clk); #1;
    req_valid = 1'b0;
    if (ok && !wr) pend_q.push_back(t);
  endtask

  task automatic rd_return();
    logic [3:0] t;
    @(posedge dram_clk); #1;
    app_rd_data_valid = 1'b1;
    if (pend_q.size() != 0) begin
      t = pend_q.pop_front();
      app_rd_data = rd_pattern(t);
      exp_q.push_back({t, rd_pattern(t)});
    end else begin
      app_rd_data = {8{$urandom()}};
    end
    @(posedge dram_clk); #1;
    app_rd_data_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge dram_clk);
      if (exp_q.size() == 0) begin done = 1; break; end
    end
    check("drain", {259'b0, done}, 260'd1);
  endtask

  always @(negedge dram_clk) begin
    if (!reset_dram && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 260'd1, 260'd0);
      else check("rsp", {rsp_tag, rsp_data}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dram = 1'b1; init_calib_complete = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wmask = '0; req_tag = '0;
    rsp_ready = 0; app_rdy = 1; app_wdf_rdy = 1; app_rd_data = '0; app_rd_data_valid = 0;
    repeat (3) @(posedge dram_clk);
    #1 reset_dram = 1'b0;

    // reset state and calibration gating
    req_valid = 1'b1; req_write = 1'b1;
    @(negedge dram_clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_app_cmd", app_cmd, 3'b001);
    check("rst_app_en", app_en, 0);
    check("rst_wren", app_wdf_wren, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_err", err_unexpected, 0);
    req_valid = 1'b0;
    init_calib_complete = 1'b1;
    @(negedge dram_clk);
    check("calib_req_ready", req_ready, 1);

    // plain write, both channels ready
    send_req(1'b1, 28'h0000010, {64{4'h5}}, 32'h0, 4'h0);
    @(negedge dram_clk);
    check("w1_en", app_en, 1);
    check("w1_wren", app_wdf_wren, 1);
    check("w1_cmd", app_cmd, 3'b000);
    check("w1_end", app_wdf_end, 1);
    check("w1_mask", app_wdf_mask, 0);
    check("w1_addr", app_addr, 28'h0000010);
    check("w1_data", app_wdf_data, {64{4'h5}});
    @(negedge dram_clk);
    check("w1_en_drop", app_en, 0);
    check("w1_wren_drop", app_wdf_wren, 0);

    // write with write-data channel stalled
    app_wdf_rdy = 1'b0;
    send_req(1'b1, 28'h0000100, {32{8'hA7}}, 32'h000000FF, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge dram_clk);
      check("w2_wren_held", app_wdf_wren, 1);
      check("w2_en", app_en, (i == 0));
      check("w2_data", app_wdf_data, {32{8'hA7}});
      check("w2_mask", app_wdf_mask, 32'h000000FF);
      check("w2_not_ready", req_ready, 0);
      if (i == 5) app_wdf_rdy = 1'b1;
    end
    @(negedge dram_clk);
    check("w2_wren_drop", app_wdf_wren, 0);
    check("w2_ready_back", req_ready, 1);

    // fill all read credits with the response port blocked
    for (int t = 0; t < 8; t++) send_req(1'b0, 28'(t * 8), '0, '0, 4'(t));
    @(posedge dram_clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_tag = 4'h8;
    repeat (3) @(negedge dram_clk);
    check("no_credit", req_ready, 0);
    req_valid = 1'b0;
    for (int t = 0; t < 8; t++) rd_return();
    @(negedge dram_clk);
    check("rsp_pending", rsp_valid, 1);
    @(posedge dram_clk); #1 rsp_ready = 1'b1;
    @(posedge dram_clk); #1 rsp_ready = 1'b0;
    @(negedge dram_clk);
    check("credit_back", req_ready, 1);
    send_req(1'b0, 28'h0000200, '0, '0, 4'h8);
    rd_return();
    drain();

    // unaligned address and read-return latency
    rsp_ready = 1'b0;
    send_req(1'b0, 28'h0000017, '0, '0, 4'h9);
    @(negedge dram_clk);
    check("align_addr", app_addr, 28'h0000010);
    check("rd_cmd", app_cmd, 3'b001);
    check("rd_no_wren", app_wdf_wren, 0);
    rd_return();
    @(negedge dram_clk);
    check("rd_latency", rsp_valid, 1);
    drain();

    // read data with nothing outstanding
    rd_return();
    @(negedge dram_clk);
    check("err_set", err_unexpected, 1);
    check("err_no_rsp", rsp_valid, 0);
    repeat (5) @(negedge dram_clk);
    check("err_sticky", err_unexpected, 1);
    check("err_no_rsp2", rsp_valid, 0);

    // reset while a command is stuck in ISSUE
    app_rdy = 1'b0;
    send_req(1'b1, 28'h0000300, {8{32'h12345678}}, 32'h0, 4'h0);
    @(negedge dram_clk);
    check("pre_rst_en", app_en, 1);
    reset_dram = 1'b1;
    #1;
    check("mid_rst_en", app_en, 0);
    check("mid_rst_wren", app_wdf_wren, 0);
    check("mid_rst_end", app_wdf_end, 0);
    check("mid_rst_cmd", app_cmd, 3'b001);
    check("mid_rst_addr", app_addr, 0);
    check("mid_rst_err", err_unexpected, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    pend_q.delete();
    exp_q.delete();
    @(posedge dram_clk); #1;
    reset_dram = 1'b0; app_rdy = 1'b1;
    send_req(1'b1, 28'h0000040, {8{32'hCAFEF00D}}, 32'hF0000000, 4'h0);
    @(negedge dram_clk);
    check("post_rst_en", app_en, 1);
    check("post_rst_cmd", app_cmd, 3'b000);
    check("post_rst_addr", app_addr, 28'h0000040);
    check("post_rst_mask", app_wdf_mask, 32'hF0000000);
    @(negedge dram_clk);
    check("post_rst_done", app_en, 0);
    check("post_rst_ready", req_ready, 1);

`ifndef DDR3_BRIDGE_STATS_EN
    check("stat_wr_off", stat_wr, 0);
    check("stat_rd_off", stat_rd, 0);
    check("stat_stall_off", stat_stall, 0);
`endif
    check("scoreboard_empty", 260'(exp_q.size()), 260'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_app_bridge.md
Name: ddr3_app_bridge

Overview:
Request front-end placed directly upstream of the DDR3 memory-interface user port (cmd/wr_data/rd_data).
- Accepts single-burst read/write requests on a valid/ready port.
- Drives the controller's independent command and write-data channels.
- Tracks outstanding reads with a credit counter and returns tagged read data, in order, on a valid/ready response port.
- Absorbs the controller's non-backpressurable rd_data_valid into an internal buffer.

Parameters:
ADDR_W, 28, app address width (byte-burst address; bits [2:0] always 0)
DATA_W, 256, burst data width
MASK_W, 32, write byte-mask width (DATA_W/8)
TAG_W, 4, request tag width
MAX_OUT, 8, max reads issued but not yet consumed at rsp port; power of 2, >=2

Ports:
dram_clk  in  1  controller user clock
reset_dram  in  1  asynchronous, active-high reset
init_calib_complete  in  1  controller calibration done
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  burst address; [2:0] ignored
req_wdata  in  DATA_W  write data
req_wmask  in  MASK_W  write byte mask (1=masked)
req_tag  in  TAG_W  returned with read data
rsp_valid  out  1  read response valid
rsp_ready  in  1  consumer ready
rsp_data  out  DATA_W  read data
rsp_tag  out  TAG_W  tag of originating read
app_cmd  out  3  000=write, 001=read
app_en  out  1  command valid
app_addr  out  ADDR_W  command address
app_rdy  in  1  controller command ready
app_wdf_data  out  DATA_W  write data
app_wdf_mask  out  MASK_W  write mask
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  last beat; equals app_wdf_wren
app_wdf_rdy  in  1  controller write-data ready
app_rd_data  in  DATA_W  read data
app_rd_data_valid  in  1  read data strobe, no backpressure
err_unexpected  out  1  sticky: rd_data_valid with no read outstanding
stat_wr, stat_rd, stat_stall  out  32 each  statistics (see Optional Feature)

Behaviour:
Reset values:
- All outputs 0; app_cmd=001 (read).
- State IDLE; credits=MAX_OUT; both FIFOs empty; cmd_acked=wd_acked=0.

Fire definitions: cmd_fire=app_en&&app_rdy; wd_fire=app_wdf_wren&&app_wdf_rdy.

State machine:
- IDLE:
  - req_ready = init_calib_complete && (req_write || credits!=0).
  - On accept, register request into app_* regs; app_addr = {req_addr[ADDR_W-1:3],3'b000}.
  - Write: assert app_en and app_wdf_wren next cycle.
  - Read: assert app_en only; decrement credits on the accept cycle.
  - Go to ISSUE.
- ISSUE:
  - app_en and app_wdf_wren are held with stable payload until their own fire; each then deasserts and sets its acked flag.
  - The two channels may fire in either order or in the same cycle.
  - Write completes when (cmd_acked||cmd_fire) && (wd_acked||wd_fire).
  - Read completes on cmd_fire; the tag is pushed to the tag FIFO on that same cycle.
  - On completion: clear acked flags, return to IDLE. No back-to-back accept in the completion cycle; throughput is 1 request per 2 cycles minimum.

Read return:
- On app_rd_data_valid: pop the tag FIFO and push {tag, app_rd_data} to the rsp FIFO (depth MAX_OUT).
- Overflow is impossible by credit accounting.
- rsp_valid = rsp FIFO not empty; rsp_data/rsp_tag come from the FIFO head (first-word-fall-through).
- A pop on rsp_valid&&rsp_ready increments credits.
- Simultaneous accept-of-read and rsp pop: credits unchanged.

Errors:
- rd_data_valid with tag FIFO empty: drop data, set err_unexpected (cleared only by reset).

Timing and reset:
- Latency: accept -> app_en = 1 cycle; app_rd_data_valid -> rsp_valid = 1 cycle.
- Reset mid-operation aborts the in-flight request; data already in the FIFOs is discarded.
- If init_calib_complete falls, the current request finishes and no new request is accepted.

Optional Feature:
DDR3_BRIDGE_STATS_EN
- Defined: stat_wr counts completed writes; stat_rd counts reads issued (cmd_fire); stat_stall counts ISSUE cycles with app_en&&!app_rdy or app_wdf_wren&&!app_wdf_rdy. All three wrap at 2^32 and are reset to 0.
- Undefined: the three ports exist but are tied to 0; no counter logic.

Decomposition:
- Package ddr3_bridge_pkg holds:
  - DRAM_WRITE=3'b000, DRAM_READ=3'b001
  - BURST_ADDR_STEP=8
  - state encodings ST_IDLE, ST_ISSUE
- Sub-module bridge_sync_fifo (parameters WIDTH, DEPTH; FWFT; full/empty; simultaneous push/pop legal) is instantiated twice: tag FIFO (TAG_W) and response FIFO (TAG_W+DATA_W).

Test Plan:
- Write addr 0x0000010, data all-0x5, app_rdy and app_wdf_rdy always 1 -> app_en and app_wdf_wren high exactly 1 cycle, app_cmd=000, app_wdf_end=1, mask=0.
- Write with app_wdf_rdy held 0 for 5 cycles, app_rdy=1 -> app_en drops after 1 cycle, wren held 6 cycles with stable data; req_ready returns 1 only after wd_fire.
- 8 reads (tags 0..7) with rsp_ready=0 -> 9th read not accepted (req_ready=0). Then rd_data_valid x8, pop one -> credits=1, 9th read accepted; rsp tags emerge 0..7 in order.
- req_addr=0x0000017 -> app_addr=0x0000010.
- app_rd_data_valid pulse with no read outstanding -> err_unexpected=1 and stays set; rsp_valid stays 0.
- Assert reset_dram during ISSUE with app_en high -> all outputs 0 immediately; after release and calib, a new write issues normally.
